// File: rtl/psum_spad_ctrl_pkg.sv
// Shared types and helpers for the PE partial-sum scratchpad sequencer.
// Saturation in the accumulate path is selected with the PSUM_SAT_EN macro.
package psum_spad_ctrl_pkg;

  localparam int PSUM_MEM_DEPTH  = 24;
  localparam int PSUM_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_ACCUM,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    OVF_NONE,
    OVF_POS,
    OVF_NEG
  } ovf_e;

  // Overflow class of a two's-complement add, from the operand and raw-sum sign bits.
  // This works at any width, so the caller clamps to its own signed max/min.
  function automatic ovf_e sat_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
    if (!a_msb && !b_msb && sum_msb) return OVF_POS;
    if (a_msb && b_msb && !sum_msb)  return OVF_NEG;
    return OVF_NONE;
  endfunction

endpackage

// File: rtl/psum_spad_ctrl_if.sv
// Bundle of control, psum-link, MAC-product and scratchpad signals around psum_spad_ctrl.
// The slave modport is the sequencer; the master modport is its environment.
interface psum_spad_ctrl_if
  import psum_spad_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(PSUM_MEM_DEPTH)
);
  logic                  start;
  logic                  load_sel;
  logic [ADDR_WIDTH-1:0] num_psum;
  logic                  psum_in_valid;
  logic                  psum_in_ready;
  logic [DATA_WIDTH-1:0] psum_in;
  logic                  prod_valid;
  logic                  prod_ready;
  logic [DATA_WIDTH-1:0] prod;
  logic [ADDR_WIDTH-1:0] prod_addr;
  logic                  acc_done;
  logic                  psum_out_valid;
  logic                  psum_out_ready;
  logic [DATA_WIDTH-1:0] psum_out;
  logic                  spad_w_en;
  logic [DATA_WIDTH-1:0] spad_din;
  logic [ADDR_WIDTH-1:0] spad_w_addr;
  logic [ADDR_WIDTH-1:0] spad_r_addr;
  logic [DATA_WIDTH-1:0] spad_dout;
  logic                  busy;

  modport slave (
    input  start, load_sel, num_psum, psum_in_valid, psum_in, prod_valid, prod,
           prod_addr, acc_done, psum_out_ready, spad_dout,
    output psum_in_ready, prod_ready, psum_out_valid, psum_out, spad_w_en,
           spad_din, spad_w_addr, spad_r_addr, busy
  );

  modport master (
    output start, load_sel, num_psum, psum_in_valid, psum_in, prod_valid, prod,
           prod_addr, acc_done, psum_out_ready, spad_dout,
    input  psum_in_ready, prod_ready, psum_out_valid, psum_out, spad_w_en,
           spad_din, spad_w_addr, spad_r_addr, busy
  );
endinterface

// File: rtl/psum_row_counter.sv
// Row pointer shared by the INIT and DRAIN phases: clear, step, and a
// terminal-count flag at the last active row; stepping past it wraps to 0.
module psum_row_counter #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] last,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  tc
);
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == last);
  assign cnt = cnt_q;

  // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = tc ? '0 : cnt_q + ADDR_WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/psum_spad_ctrl.sv
// Partial-sum scratchpad sequencer: init (zero/upstream), single-cycle RMW accumulate, drain.
// Define PSUM_SAT_EN to saturate the accumulate add; by default it wraps.
module psum_spad_ctrl
  import psum_spad_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH  = PSUM_MEM_DEPTH,
  parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  psum_spad_ctrl_if.slave  bus
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] n_last_q, n_last_d;
  logic                  load_sel_q, load_sel_d;

  logic [ADDR_WIDTH-1:0] row_cnt;
  logic                  row_tc, row_inc, row_clr;
  logic                  init_step;
  logic [DATA_WIDTH-1:0] raw_sum, acc_sum;

  psum_row_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_row_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (row_clr),
    .inc  (row_inc),
    .last (n_last_q),
    .cnt  (row_cnt),
    .tc   (row_tc)
  );

  // Zero-fill advances every cycle; upstream load only on an accepted beat.
  assign init_step = !load_sel_q || bus.psum_in_valid;

  always_comb begin
    raw_sum = bus.spad_dout + bus.prod;
    acc_sum = raw_sum;
`ifdef PSUM_SAT_EN
    case (sat_ovf(bus.spad_dout[DATA_WIDTH-1], bus.prod[DATA_WIDTH-1], raw_sum[DATA_WIDTH-1]))
      OVF_POS: acc_sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      OVF_NEG: acc_sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      default: acc_sum = raw_sum;
    endcase
`endif
  end

  // Pass configuration is captured only when a start is accepted; N=0 runs as N=1.
  always_comb begin
    n_last_d   = n_last_q;
    load_sel_d = load_sel_q;
    if (state_q == ST_IDLE && bus.start) begin
      load_sel_d = bus.load_sel;
      if (bus.num_psum == '0)                     n_last_d = '0;
      else if (int'(bus.num_psum) > MEM_DEPTH - 1) n_last_d = ADDR_WIDTH'(MEM_DEPTH - 2);
      else                                        n_last_d = bus.num_psum - ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_last_q   <= '0;
      load_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_last_q   <= n_last_d;
      load_sel_q <= load_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start)                   state_d = ST_INIT;
      ST_INIT:  if (init_step && row_tc)         state_d = ST_ACCUM;
      ST_ACCUM: if (bus.acc_done)                state_d = ST_DRAIN;
      ST_DRAIN: if (bus.psum_out_ready && row_tc) state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.psum_in_ready  = 1'b0;
    bus.prod_ready     = 1'b0;
    bus.psum_out_valid = 1'b0;
    bus.psum_out       = '0;
    bus.spad_w_en      = 1'b0;
    bus.spad_din       = '0;
    bus.spad_w_addr    = '0;
    bus.spad_r_addr    = '0;
    bus.busy           = (state_q != ST_IDLE);
    row_inc            = 1'b0;
    row_clr            = 1'b0;
    case (state_q)
      ST_IDLE: row_clr = bus.start;
      ST_INIT: begin
        bus.psum_in_ready = load_sel_q;
        bus.spad_w_en     = init_step;
        bus.spad_w_addr   = row_cnt;
        bus.spad_din      = load_sel_q ? bus.psum_in : '0;
        row_inc           = init_step;
      end
      ST_ACCUM: begin
        // Read lands on the falling edge, so the sum is written at the closing rising edge.
        bus.prod_ready  = 1'b1;
        bus.spad_r_addr = bus.prod_addr;
        if (bus.prod_valid && bus.prod_addr <= n_last_q) begin
          bus.spad_w_en   = 1'b1;
          bus.spad_w_addr = bus.prod_addr;
          bus.spad_din    = acc_sum;
        end
        row_clr = bus.acc_done;
      end
      ST_DRAIN: begin
        bus.spad_r_addr    = row_cnt;
        bus.psum_out_valid = 1'b1;
        bus.psum_out       = bus.spad_dout;
        row_inc            = bus.psum_out_ready;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_psum_spad_ctrl.sv
// Directed bench for psum_spad_ctrl with a scratchpad model and a row-level psum model.
// The compare process checks every drained row against the model's expected queue.
module tb_psum_spad_ctrl;
  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_spad_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  psum_spad_ctrl #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scratchpad: write on the rising edge, read on the falling edge.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.spad_w_en && int'(bus.spad_w_addr) < DEPTH) mem[bus.spad_w_addr] <= bus.spad_din;
  always @(negedge clk) bus.spad_dout <= (int'(bus.spad_r_addr) < DEPTH) ? mem[bus.spad_r_addr] : '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model state for one pass.
  logic [DW-1:0] init_v [DEPTH];
  logic [DW-1:0] p_val  [8];
  logic [AW-1:0] p_addr [8];
  int            n_prod;
  bit            last_with_done;
  bit            rdy_pat [4];
  logic [DW-1:0] rows [DEPTH];
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] m_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef PSUM_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return DW'(s);
  endfunction

  task automatic model_pass(input bit ls, input int n);
    for (int i = 0; i < n; i++) rows[i] = ls ? init_v[i] : '0;
    for (int j = 0; j < n_prod; j++)
      if (int'(p_addr[j]) < n) rows[p_addr[j]] = m_add(rows[p_addr[j]], p_val[j]);
    for (int i = 0; i < n; i++) exp_q.push_back(rows[i]);
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst && bus.psum_out_valid) begin
      if (exp_q.size() == 0) check("drain_extra_row", 32'd1, 32'd0);
      else begin
        check("drain_row", bus.psum_out, exp_q[0]);
        if (bus.psum_out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_pass(input bit ls, input int n_raw);
    int n, cnt, exp_cyc, ones;
    n = (n_raw == 0) ? 1 : n_raw;
    model_pass(ls, n);
    bus.start = 1'b1; bus.load_sel = ls; bus.num_psum = AW'(n_raw);
    tick;
    bus.start = 1'b0;
    check("busy_in_init", bus.busy, 1);
    cnt = 0;
    if (!ls) begin
      while (!bus.prod_ready && cnt < 200) begin
        check("zf_wen", bus.spad_w_en, 1);
        check("zf_waddr", bus.spad_w_addr, cnt);
        check("zf_din", bus.spad_din, 0);
        cnt++;
        tick;
      end
      check("zf_cycles", cnt, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i == 1) begin
          bus.psum_in_valid = 1'b0;
          #1;
          check("load_gap_wen", bus.spad_w_en, 0);
          tick;
        end
        bus.psum_in_valid = 1'b1; bus.psum_in = init_v[i];
        #1;
        check("load_ready", bus.psum_in_ready, 1);
        check("load_waddr", bus.spad_w_addr, i);
        tick;
      end
      bus.psum_in_valid = 1'b0;
    end
    check("accum_prod_ready", bus.prod_ready, 1);
    for (int j = 0; j < n_prod; j++) begin
      bus.prod_valid = 1'b1; bus.prod = p_val[j]; bus.prod_addr = p_addr[j];
      bus.acc_done = last_with_done && (j == n_prod - 1);
      bus.start = (j == 0);
      #1;
      check("accum_wen", bus.spad_w_en, int'(p_addr[j]) < n);
      tick;
    end
    bus.start = 1'b0; bus.prod_valid = 1'b0;
    if (!(last_with_done && n_prod > 0)) begin
      bus.acc_done = 1'b1;
      tick;
    end
    bus.acc_done = 1'b0;
    exp_cyc = 0; ones = 0;
    while (ones < n) begin
      if (rdy_pat[exp_cyc % 4]) ones++;
      exp_cyc++;
    end
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      bus.psum_out_ready = rdy_pat[cnt % 4];
      tick;
      cnt++;
    end
    bus.psum_out_ready = 1'b0;
    check("drain_cycles", cnt, exp_cyc);
    check("drain_all_rows", exp_q.size(), 0);
    check("idle_after_drain", bus.busy, 0);
    check("no_valid_in_idle", bus.psum_out_valid, 0);
  endtask

  task automatic all_ready;
    for (int i = 0; i < 4; i++) rdy_pat[i] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    bus.start = 0; bus.load_sel = 0; bus.num_psum = '0;
    bus.psum_in_valid = 0; bus.psum_in = '0;
    bus.prod_valid = 0; bus.prod = '0; bus.prod_addr = '0;
    bus.acc_done = 0; bus.psum_out_ready = 0;
    rst = 1'b1;
    repeat (2) tick;
    check("rst_busy", bus.busy, 0);
    check("rst_prod_ready", bus.prod_ready, 0);
    check("rst_psum_in_ready", bus.psum_in_ready, 0);
    check("rst_out_valid", bus.psum_out_valid, 0);
    check("rst_wen", bus.spad_w_en, 0);
    check("rst_addrs", {bus.spad_w_addr, bus.spad_r_addr}, 0);
    check("rst_psum_out", bus.psum_out, 0);
    rst = 1'b0;
    tick;

    // Zero-fill N=4, drain all zeros.
    n_prod = 0; last_with_done = 0; all_ready();
    run_pass(1'b0, 4);

    // Load 10,20,30 then 5@0, -3@2, 7@0 back-to-back.
    init_v[0] = 16'd10; init_v[1] = 16'd20; init_v[2] = 16'd30;
    p_val[0] = 16'd5;    p_addr[0] = 5'd0;
    p_val[1] = 16'hFFFD; p_addr[1] = 5'd2;
    p_val[2] = 16'd7;    p_addr[2] = 5'd0;
    n_prod = 3;
    run_pass(1'b1, 3);
    check("model_t2_r0", rows[0], 22);
    check("model_t2_r1", rows[1], 20);
    check("model_t2_r2", rows[2], 27);

    // N=23 boundary: row 22 updated, address 23 dropped.
    p_val[0] = 16'd9;    p_addr[0] = 5'd22;
    p_val[1] = 16'd4;    p_addr[1] = 5'd23;
    p_val[2] = 16'hFFFE; p_addr[2] = 5'd22;
    n_prod = 3;
    run_pass(1'b0, 23);
    check("model_t3_r22", rows[22], 7);

    // Stalled drain with ready 1,0,0,1 and a product in the acc_done cycle.
    for (int i = 0; i < 4; i++) init_v[i] = DW'(i + 1);
    p_val[0] = 16'd100; p_addr[0] = 5'd1;
    n_prod = 1; last_with_done = 1;
    rdy_pat[0] = 1; rdy_pat[1] = 0; rdy_pat[2] = 0; rdy_pat[3] = 1;
    run_pass(1'b1, 4);
    check("model_t4_r1", rows[1], 102);
    last_with_done = 0; all_ready();

    // Overflow at the positive limit.
    init_v[0] = 16'h7FFF;
    p_val[0] = 16'd1; p_addr[0] = 5'd0;
    n_prod = 1;
    run_pass(1'b1, 1);
`ifdef PSUM_SAT_EN
    check("model_sat_r0", rows[0], 32'h7FFF);
`else
    check("model_wrap_r0", rows[0], 32'h8000);
`endif

    // num_psum=0 runs as one row; address 1 is out of range.
    p_val[0] = 16'd5; p_addr[0] = 5'd0;
    p_val[1] = 16'd3; p_addr[1] = 5'd1;
    n_prod = 2;
    run_pass(1'b0, 0);
    check("model_t6_r0", rows[0], 5);

    // Reset mid-ACCUM, then a fresh pass.
    bus.start = 1'b1; bus.load_sel = 1'b0; bus.num_psum = 5'd2;
    tick;
    bus.start = 1'b0;
    repeat (2) tick;
    check("pre_rst_prod_ready", bus.prod_ready, 1);
    bus.prod_valid = 1'b1; bus.prod = 16'd5; bus.prod_addr = 5'd0;
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_prod_ready", bus.prod_ready, 0);
    check("mid_rst_wen", bus.spad_w_en, 0);
    tick;
    bus.prod_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    tick;
    n_prod = 0;
    run_pass(1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
